// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM encoding,
// parity helper and a constant-foldable clog2.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Widest supported word; narrower words are zero-extended before parity.
  localparam int MAX_DATA_BITS = 9;

  // Expected parity bit: XOR of the data, inverted for odd parity.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     odd);
    return (^data) ^ odd;
  endfunction

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rxfifo_param.sv
// Show-ahead receive FIFO with exact occupancy. A read on an empty FIFO is
// ignored; a write into a full FIFO is accepted only when a read frees a slot
// in the same cycle.
module rxfifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_i,
  input  logic [DATA_BITS-1:0]          wr_data_i,
  input  logic                          rd_i,
  output logic [DATA_BITS-1:0]          rd_data_o,
  output logic [clog2_f(FIFO_DEPTH):0]  level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int              AW      = clog2_f(FIFO_DEPTH);
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 do_rd, do_wr;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH_L);
  assign do_rd     = rd_i && !empty_o;
  assign do_wr     = wr_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(negedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-point majority sampling,
// start-glitch rejection, optional parity, break detection, sticky error
// flags and a show-ahead receive FIFO towards the host.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0,
  parameter int FIFO_DEPTH    = 4,
  parameter int CTS_THRESH    = FIFO_DEPTH - 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serin,
  input  logic                          host_rd,
  output logic [DATA_BITS-1:0]          host_dout,
  output logic                          host_dor,
  input  logic                          err_clr,
  output logic                          frame_error,
  output logic                          parity_error,
  output logic                          overrun,
  output logic                          break_det,
  output logic                          cts,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int            CW         = clog2_f(TICKS_PER_BIT);
  localparam int            LW         = clog2_f(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CTR_ONE    = CW'(1);
  localparam logic [CW-1:0] CTR_MID_M1 = CW'(TICKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CTR_MID    = CW'(TICKS_PER_BIT/2);
  localparam logic [CW-1:0] CTR_DEC    = CW'(TICKS_PER_BIT/2 + 1);
  localparam logic [CW-1:0] CTR_LAST   = CW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST   = 4'(DATA_BITS - 1);
  localparam logic [LW-1:0] CTS_L      = LW'(CTS_THRESH);
  localparam logic          PAR_EN_L   = (PARITY_EN != 0);
  localparam logic          PAR_ODD_L  = (PARITY_ODD != 0);

  rx_state_e            state_q;
  logic                 sync1_q, sync2_q, sprev_q;
  logic [CW-1:0]        ctr_q;
  logic [3:0]           idx_q;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 pbit_q;
  logic                 par_pend_q;
  logic                 frame_error_q, parity_error_q, overrun_q, break_det_q;

  logic                     s, maj, at_dec, at_end;
  logic                     push, brk_cond, fe_set, pe_set, ov_set;
  logic                     fifo_full, fifo_empty;
  logic [MAX_DATA_BITS-1:0] data_ext;
  logic [LW-1:0]            level;

  assign s        = sync2_q;
  assign maj      = (smp_q[0] & smp_q[1]) | (smp_q[0] & s) | (smp_q[1] & s);
  assign at_dec   = (ctr_q == CTR_DEC);
  assign at_end   = (ctr_q == CTR_LAST);
  assign brk_cond = (sh_q == '0) && (!PAR_EN_L || !pbit_q);
  assign push     = (state_q == ST_STOP) && at_dec && maj;
  assign fe_set   = (state_q == ST_STOP) && at_dec && !maj && !brk_cond;
  assign pe_set   = push && par_pend_q;
  assign ov_set   = push && fifo_full && !host_rd;

  // Zero-extend the received word so one parity helper covers every width.
  always_comb begin
    data_ext                  = '0;
    data_ext[DATA_BITS-1:0]   = sh_q;
  end

  // Two-flop synchroniser plus one delayed copy for start-edge detection.
  always_ff @(negedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sprev_q <= 1'b1;
    end else begin
      sync1_q <= serin;
      sync2_q <= sync1_q;
      sprev_q <= sync2_q;
    end
  end

  // Sample capture and word shift register (datapath, no reset needed).
  always_ff @(negedge clk) begin
    if (ctr_q == CTR_MID_M1) smp_q[0] <= s;
    if (ctr_q == CTR_MID)    smp_q[1] <= s;
    if (state_q == ST_DATA && at_dec)   sh_q   <= {maj, sh_q[DATA_BITS-1:1]};
    if (state_q == ST_PARITY && at_dec) pbit_q <= maj;
  end

  // Receive FSM with registered status flags; a set wins over err_clr.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ctr_q          <= '0;
      idx_q          <= '0;
      par_pend_q     <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      overrun_q      <= 1'b0;
      break_det_q    <= 1'b0;
    end else begin
      frame_error_q  <= fe_set | (frame_error_q  & ~err_clr);
      parity_error_q <= pe_set | (parity_error_q & ~err_clr);
      overrun_q      <= ov_set | (overrun_q      & ~err_clr);
      case (state_q)
        ST_IDLE: begin
          ctr_q <= '0;
          if (sprev_q && !s) begin
            state_q    <= ST_START;
            par_pend_q <= 1'b0;
          end
        end
        ST_START: begin
          ctr_q <= ctr_q + CTR_ONE;
          if (at_dec && maj) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
          end else if (at_end) begin
            state_q <= ST_DATA;
            ctr_q   <= '0;
            idx_q   <= '0;
          end
        end
        ST_DATA: begin
          ctr_q <= ctr_q + CTR_ONE;
          if (at_end) begin
            ctr_q <= '0;
            if (idx_q == IDX_LAST) state_q <= PAR_EN_L ? ST_PARITY : ST_STOP;
            else                   idx_q   <= idx_q + 4'd1;
          end
        end
        ST_PARITY: begin
          ctr_q <= ctr_q + CTR_ONE;
          if (at_dec) par_pend_q <= (maj != calc_parity(data_ext, PAR_ODD_L));
          if (at_end) begin
            state_q <= ST_STOP;
            ctr_q   <= '0;
          end
        end
        ST_STOP: begin
          ctr_q <= ctr_q + CTR_ONE;
          if (at_dec) begin
            ctr_q <= '0;
            if (!maj && brk_cond) begin
              state_q     <= ST_BREAK;
              break_det_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          ctr_q <= '0;
          if (s) begin
            state_q     <= ST_IDLE;
            break_det_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ctr_q   <= '0;
        end
      endcase
    end
  end

  rxfifo_param #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (push),
    .wr_data_i (sh_q),
    .rd_i      (host_rd),
    .rd_data_o (host_dout),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign host_dor     = !fifo_empty;
  assign fifo_level   = level;
  assign cts          = (level < CTS_L);
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;
  assign overrun      = overrun_q;
  assign break_det    = break_det_q;

endmodule
